bpm_display_driver: RTL and testbench
=====================================

BPM_DISPLAY_DRIVER -- requirements
Module: bpm_display_driver

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 10_000_000, meaning system clock frequency.
REQ-002 SHALL have parameter DIGIT_HZ, default 1_000, meaning per-digit scan rate; DIGIT_PERIOD = CLK_FREQ_HZ/DIGIT_HZ cycles (10_000 by default).
REQ-003 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port bpm_in  input  8  latched BPM value from the control unit (unsigned, 0..255).
REQ-006 SHALL have port bpm_load  input  1  one-cycle strobe meaning "bpm_in is new".
REQ-007 SHALL have port seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port an_n  output  3  digit anodes {hundreds,tens,ones}, active-low, one-hot or all-high.
REQ-009 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when new digits are committed.

Function
REQ-011 SHALL implement FSM IDLE -> CONVERT -> COMMIT -> IDLE.
REQ-012 IDLE: on bpm_load=1, capture bpm_in into shift register {12'b0, bpm_in}, clear iteration count, go to CONVERT.
REQ-013 CONVERT: each cycle add 3 to each BCD nibble >= 5, then shift the 20-bit register left by 1; after the 8th shift go to COMMIT.
REQ-014 COMMIT: copy the 12-bit BCD result into the display digit registers, assert done, go to IDLE.
REQ-015 Latency SHALL be fixed: bpm_load sampled at edge E0; busy=1 from E0 to E9; done=1 between E8 and E9; digits visible from E9.
REQ-016 bpm_load during CONVERT SHALL restart the conversion with the new bpm_in, discarding partial results, so the last value wins.
REQ-017 bpm_load during COMMIT SHALL complete the commit (done=1) and start a new conversion at the same edge, with the state going to CONVERT.
REQ-018 A blank flag SHALL be registered each cycle as (bpm_in == 0); while it is set, seg_n = 7'h7F for every digit, regardless of the digit registers.
REQ-019 Scan counter SHALL count 0..DIGIT_PERIOD-1 and wrap; on wrap, the digit select SHALL advance ones -> tens -> hundreds -> ones.
REQ-020 an_n SHALL drive low only the selected digit: ones = 3'b110, tens = 3'b101, hundreds = 3'b011.
REQ-021 Leading-zero blanking: hundreds SHALL be dark (seg_n = 7'h7F) if it is 0; tens SHALL be dark if both hundreds and tens are 0; ones SHALL always be lit unless the blank flag is set.
REQ-022 Segment decode (seg_n hex) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-023 BCD nibbles SHALL never exceed 9; inputs 0..255 SHALL produce hundreds <= 2.
REQ-024 Scanning SHALL run continuously and independently of FSM state; a conversion SHALL NOT stall the scan.
REQ-025 seg_n and an_n SHALL be registered outputs, updating one cycle after the select or digit change.

Reset
REQ-026 On rst_n=0: state=IDLE, shift register=0, digit registers=0, blank flag=1, scan counter=0, select=ones.
REQ-027 Output reset values SHALL be: seg_n=7'h7F, an_n=3'b111, busy=0, done=0.
REQ-028 Reset asserted mid-conversion SHALL abort it with no done pulse; after release, the block SHALL be idle with a dark display.

Structure
REQ-029 Shared package bpm_pkg SHALL hold the state encoding, the 7-segment decode table, and the SEG_BLANK=7'h7F and AN_OFF=3'b111 constants.
REQ-030 The sequential double-dabble converter SHALL be sub-module bin2bcd_seq (ports: clk, rst_n, start, bin[7:0], busy, done, bcd[11:0]).
REQ-031 The scan/decode logic SHALL remain in bpm_display_driver; the bench SHALL use DIGIT_PERIOD = 4 via parameters.

Verification
REQ-032 Reset, then bpm_in=72 with load -> done 9 cycles later; digits {hundreds dark, tens 78, ones 24}; busy high for exactly 9 cycles.
REQ-033 bpm_in=255 with load -> hundreds 24, tens 12, ones 12; the an_n sequence is 110, 101, 011, repeating every 4 cycles per digit.
REQ-034 Load 100, then load 60 on the 3rd CONVERT cycle -> exactly one done pulse, with the displayed value 60 (hundreds dark, tens 02, ones 40).
REQ-035 Load in the COMMIT cycle (7 then 200) -> done for 7, then done for 200 exactly 9 cycles later; final display {24, 40, 40}.
REQ-036 After value 88 is displayed, set bpm_in=0 with no load -> seg_n = 7F on all digits within 2 cycles while an_n keeps scanning.
REQ-037 Assert rst_n low at the 4th CONVERT cycle -> an_n=111, seg_n=7F, busy=0 immediately; no done pulse ever follows.

Source files
------------

// File: rtl/bpm_pkg.sv
// bpm_pkg: shared types and constants for the BPM display driver.
// Holds the converter state encoding, digit select, and 7-segment decode.
package bpm_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_COMMIT} state_e;
   typedef enum logic [1:0] {SEL_ONES, SEL_TENS, SEL_HUNDREDS} sel_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [2:0] AN_OFF    = 3'b111;

   // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 stays dark.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return SEG_BLANK;
      endcase
   endfunction

   function automatic logic [3:0] dd_adjust(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, 8-bit binary to 3 BCD digits in 8 shifts.
// A start in any state reloads the register, so the most recent value always wins.
module bin2bcd_seq
   import bpm_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  bin,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd
);

   state_e      state_q, state_d;
   logic [19:0] sr_q, sr_d, adj;
   logic [2:0]  cnt_q, cnt_d;

   assign adj = {dd_adjust(sr_q[19:16]), dd_adjust(sr_q[15:12]), dd_adjust(sr_q[11:8]), sr_q[7:0]};

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      if (start) begin
         state_d = ST_CONVERT;
         sr_d    = {12'b0, bin};
         cnt_d   = '0;
      end else if (state_q == ST_CONVERT) begin
         sr_d    = {adj[18:0], 1'b0};
         cnt_d   = cnt_q + 3'd1;
         state_d = (cnt_q == 3'd7) ? ST_COMMIT : ST_CONVERT;
      end else if (state_q == ST_COMMIT) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_COMMIT);
   assign bcd  = sr_q[19:8];

endmodule

// File: rtl/bpm_display_driver.sv
// bpm_display_driver: converts a BPM value to BCD and multiplexes it onto a
// 3-digit common-anode 7-segment display with leading-zero blanking.
module bpm_display_driver
   import bpm_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 10_000_000,
   parameter int DIGIT_HZ    = 1_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] bpm_in,
   input  logic       bpm_load,
   output logic [6:0] seg_n,
   output logic [2:0] an_n,
   output logic       busy,
   output logic       done
);

   localparam int DIGIT_PERIOD = CLK_FREQ_HZ / DIGIT_HZ;
   localparam int CW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;

   logic [11:0]   bcd, dig_q, dig_d;
   logic          conv_done, blank_q, wrap, dark;
   logic [CW-1:0] scan_q, scan_d;
   sel_e          sel_q, sel_d;
   logic [3:0]    nib;
   logic [6:0]    seg_q, seg_d;
   logic [2:0]    an_q, an_d;

   bin2bcd_seq u_conv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (bpm_load),
      .bin   (bpm_in),
      .busy  (busy),
      .done  (conv_done),
      .bcd   (bcd)
   );

   always_comb begin
      dig_d  = conv_done ? bcd : dig_q;
      wrap   = (scan_q == CW'(DIGIT_PERIOD - 1));
      scan_d = wrap ? '0 : scan_q + CW'(1);
      sel_d  = !wrap ? sel_q : (sel_q == SEL_ONES) ? SEL_TENS : (sel_q == SEL_TENS) ? SEL_HUNDREDS : SEL_ONES;
      nib    = (sel_q == SEL_HUNDREDS) ? dig_q[11:8] : (sel_q == SEL_TENS) ? dig_q[7:4] : dig_q[3:0];
      // Leading zeros go dark; the ones digit is only darkened by the blank flag.
      dark   = blank_q | ((sel_q == SEL_HUNDREDS) & ~|dig_q[11:8]) | ((sel_q == SEL_TENS) & ~|dig_q[11:4]);
      seg_d  = dark ? SEG_BLANK : seg_decode(nib);
      an_d   = (sel_q == SEL_HUNDREDS) ? 3'b011 : (sel_q == SEL_TENS) ? 3'b101 : 3'b110;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dig_q   <= '0;
         blank_q <= 1'b1;
         scan_q  <= '0;
         sel_q   <= SEL_ONES;
         seg_q   <= SEG_BLANK;
         an_q    <= AN_OFF;
      end else begin
         dig_q   <= dig_d;
         blank_q <= (bpm_in == 8'd0);
         scan_q  <= scan_d;
         sel_q   <= sel_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign seg_n = seg_q;
   assign an_n  = an_q;
   assign done  = conv_done;

endmodule

// File: tb/tb_bpm_display_driver.sv
// tb_bpm_display_driver: directed stimulus against an arithmetic model of the
// display driver, plus hand-computed digit patterns for the key scenarios.
module tb_bpm_display_driver;

   localparam int P = 4;

   logic       clk, rst_n, bpm_load;
   logic [7:0] bpm_in;
   logic [6:0] seg_n;
   logic [2:0] an_n;
   logic       busy, done;

   int total = 0;
   int bad = 0;
   int ncyc = 0;
   int busy_cnt = 0;
   int dq[$];

   // model state
   bit         m_busy;
   int         m_cyc, m_pend, m_disp, m_scan, m_sel;
   bit         m_blank;
   logic [6:0] m_seg;
   logic [2:0] m_an;
   logic [6:0] segs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   bpm_display_driver #(.CLK_FREQ_HZ(4_000), .DIGIT_HZ(1_000)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bpm_in   (bpm_in),
      .bpm_load (bpm_load),
      .seg_n    (seg_n),
      .an_n     (an_n),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] exp_seg(input int sel, input int v, input bit blank);
      int h, t, o;
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      if (blank) return 7'h7F;
      if (sel == 2) return (h == 0) ? 7'h7F : segs[h];
      if (sel == 1) return (h == 0 && t == 0) ? 7'h7F : segs[t];
      return segs[o];
   endfunction

   function automatic logic [2:0] exp_an(input int sel);
      return (sel == 2) ? 3'b011 : (sel == 1) ? 3'b101 : 3'b110;
   endfunction

   // Behavioural model: a load starts a 9-cycle job whose value appears on the display afterwards.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_cyc = 0; m_pend = 0; m_disp = 0;
         m_blank = 1; m_scan = 0; m_sel = 0;
         m_seg = 7'h7F; m_an = 3'b111;
      end else begin
         m_seg = exp_seg(m_sel, m_disp, m_blank);
         m_an  = exp_an(m_sel);
         if (m_busy && m_cyc == 8) m_disp = m_pend;
         if (bpm_load) begin
            m_pend = int'(bpm_in); m_cyc = 0; m_busy = 1;
         end else if (m_busy) begin
            if (m_cyc == 8) m_busy = 0;
            else m_cyc++;
         end
         m_blank = (bpm_in == 0);
         if (m_scan == P - 1) begin
            m_scan = 0;
            m_sel = (m_sel + 1) % 3;
         end else m_scan++;
      end
   end

   always @(posedge clk) ncyc++;

   always @(negedge clk) begin
      check("seg_n", seg_n, m_seg);
      check("an_n", an_n, m_an);
      check("busy", busy, m_busy);
      check("done", done, m_busy && m_cyc == 8);
      if (busy) busy_cnt++;
      if (done) dq.push_back(ncyc);
   end

   task automatic load(input logic [7:0] v);
      @(negedge clk);
      bpm_in = v;
      bpm_load = 1;
      @(negedge clk);
      bpm_load = 0;
   endtask

   task automatic see_digit(input logic [2:0] an, input logic [6:0] exp, input string name);
      int n = 0;
      while (an_n !== an && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({name, "_an"}, an_n, an);
      check(name, seg_n, exp);
   endtask

   initial begin
      int e0, n;
      logic [2:0] pat [3] = '{3'b110, 3'b101, 3'b011};
      rst_n = 0;
      bpm_in = 0;
      bpm_load = 0;
      repeat (3) @(negedge clk);
      check("rst_seg", seg_n, 7'h7F);
      check("rst_an", an_n, 3'b111);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n = 1;
      repeat (2) @(negedge clk);

      busy_cnt = 0;
      dq.delete();
      load(72);
      e0 = ncyc;
      repeat (12) @(negedge clk);
      check("t72_done_n", dq.size(), 1);
      check("t72_done_cycle", (dq.size() > 0) ? dq[0] - e0 + 1 : 0, 9);
      check("t72_busy_cycles", busy_cnt, 9);
      see_digit(3'b011, 7'h7F, "t72_h");
      see_digit(3'b101, 7'h78, "t72_t");
      see_digit(3'b110, 7'h24, "t72_o");

      load(255);
      repeat (10) @(negedge clk);
      see_digit(3'b011, 7'h24, "t255_h");
      see_digit(3'b101, 7'h12, "t255_t");
      see_digit(3'b110, 7'h12, "t255_o");
      n = 0;
      while (an_n !== 3'b011 && n < 20) begin @(negedge clk); n++; end
      while (an_n !== 3'b110 && n < 40) begin @(negedge clk); n++; end
      for (int i = 0; i < 12; i++) begin
         check("scan_seq", an_n, pat[i / 4]);
         @(negedge clk);
      end

      dq.delete();
      load(100);
      @(negedge clk);
      load(60);
      repeat (12) @(negedge clk);
      check("t60_done_n", dq.size(), 1);
      see_digit(3'b011, 7'h7F, "t60_h");
      see_digit(3'b101, 7'h02, "t60_t");
      see_digit(3'b110, 7'h40, "t60_o");

      dq.delete();
      load(7);
      repeat (7) @(negedge clk);
      load(200);
      repeat (12) @(negedge clk);
      check("t200_done_n", dq.size(), 2);
      check("t200_gap", (dq.size() == 2) ? dq[1] - dq[0] : 0, 9);
      see_digit(3'b011, 7'h24, "t200_h");
      see_digit(3'b101, 7'h40, "t200_t");
      see_digit(3'b110, 7'h40, "t200_o");

      load(88);
      repeat (12) @(negedge clk);
      see_digit(3'b011, 7'h7F, "t88_h");
      see_digit(3'b101, 7'h00, "t88_t");
      see_digit(3'b110, 7'h00, "t88_o");
      bpm_in = 0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         check("blank_seg", seg_n, 7'h7F);
         check("blank_an_lit", an_n != 3'b111, 1);
         @(negedge clk);
      end

      load(150);
      repeat (3) @(negedge clk);
      #2 rst_n = 0;
      bpm_in = 0;
      #1;
      check("abort_an", an_n, 3'b111);
      check("abort_seg", seg_n, 7'h7F);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      dq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (20) @(negedge clk);
      check("abort_no_done", dq.size(), 0);
      check("abort_idle", busy, 0);
      check("abort_dark", seg_n, 7'h7F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
